// File: rtl/mem_responder.sv
// mem_responder: single-port word memory behind a multi-cycle request handshake.
// A request is latched in idle, waits WAIT_CYCLES edges, then completes with a
// one-cycle ready pulse carrying registered read data and an error flag.
module mem_responder #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;
  localparam logic [CW-1:0] WAIT_LOAD = CW'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic            write_q, write_d;
  logic            bad_q, bad_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [DW-1:0]   mem_q [DEPTH_WORDS];

  logic            accept;
  logic            req_bad;
  logic            done_next;
  logic            mem_we;

  // Request decode: acceptance and error classification of the live inputs
  always_comb begin
    accept  = (state_q == S_IDLE) && (MemRead || MemWrite);
    req_bad = (MemRead && MemWrite)
           || (addr[1:0] != 2'b00)
           || ({2'b00, addr[31:2]} >= DW'(DEPTH_WORDS));
  end

  // Next-state, request latch and output next values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    write_d = write_q;
    bad_d   = bad_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    ready_d = 1'b0;
    busy_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          idx_d   = addr[AW+1:2];
          wdata_d = wdata;
          write_d = MemWrite && !MemRead;
          bad_d   = req_bad;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // The _d request fields already hold the live request on a zero-wait accept
    done_next = (state_d == S_DONE);
    ready_d   = done_next;
    busy_d    = (state_d != S_IDLE);
    if (done_next) begin
      err_d = bad_d;
      if (!bad_d && !write_d) begin
        rdata_d = mem_q[idx_d];
      end
    end
  end

  // Memory write strobe, suppressed while reset holds the FSM in idle
  always_comb begin
    mem_we = nrst && done_next && write_d && !bad_d;
  end

  // Control and status registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      bad_q   <= 1'b0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      bad_q   <= bad_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[idx_d] <= wdata_d;
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
